// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the data port and the shared memory port of the arbiter.
// Latency: none (wires only).
// Backpressure: stall/done handshake carried per port; memory completion by mem_done pulse.
interface mem_arbiter_if;
  // fetch port (read-only)
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data_out;
  logic        i_done;
  logic        i_stall;
  logic        i_err;
  // data port (read/write)
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wr_data;
  logic [15:0] d_data_out;
  logic        d_done;
  logic        d_stall;
  logic        d_err;
  // shared memory
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_done;
  logic        mem_stall;
  logic [15:0] mem_data_out;
  logic        mem_err;

  // arbiter side
  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wr_data,
    input  mem_done, mem_stall, mem_data_out, mem_err,
    output i_data_out, i_done, i_stall, i_err,
    output d_data_out, d_done, d_stall, d_err,
    output mem_rd, mem_wr, mem_addr, mem_data_in
  );

  // requester/memory side
  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_wr_data,
    output mem_done, mem_stall, mem_data_out, mem_err,
    input  i_data_out, i_done, i_stall, i_err,
    input  d_data_out, d_done, d_stall, d_err,
    input  mem_rd, mem_wr, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and data (D) ports onto one multi-cycle memory; D has priority, I gets a starvation guard.
// Latency: issue in the request cycle when IDLE; done in the mem_done cycle; next issue one cycle after done.
// Backpressure: requesters see x_stall until x_done; one outstanding memory access at a time.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        err_q, err_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic d_req;
  logic d_illegal;
  logic i_forced;

  // mem_stall is informational only; sequencing relies on mem_done
  logic unused_mem_stall;
  assign unused_mem_stall = bus.mem_stall;

  assign d_req     = bus.d_rd | bus.d_wr;
  assign d_illegal = bus.d_rd & bus.d_wr;
  // I is forced through once D has won LIMIT grants in a row while I waited
  assign i_forced  = bus.i_rd && (starve_cnt_q == LIMIT);

  // Next-state, issue and completion logic
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = 16'h0;
    bus.mem_data_in = 16'h0;
    bus.i_done      = 1'b0;
    bus.i_err       = 1'b0;
    bus.i_data_out  = 16'h0;
    bus.d_done      = 1'b0;
    bus.d_err       = 1'b0;
    bus.d_data_out  = 16'h0;

    unique case (state_q)
      IDLE: begin
        if (d_illegal) begin
          // read+write together is rejected on the spot; I is held off this cycle too
          bus.d_done = 1'b1;
          bus.d_err  = 1'b1;
        end else if (d_req && !i_forced) begin
          bus.mem_rd      = bus.d_rd;
          bus.mem_wr      = bus.d_wr;
          bus.mem_addr    = bus.d_addr;
          bus.mem_data_in = bus.d_wr_data;
          addr_d          = bus.d_addr;
          wdata_d         = bus.d_wr_data;
          err_d           = bus.mem_err;
          state_d         = BUSY_D;
          if (bus.i_rd) begin
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end else if (bus.i_rd) begin
          bus.mem_rd      = 1'b1;
          bus.mem_addr    = bus.i_addr;
          bus.mem_data_in = 16'h0;
          addr_d          = bus.i_addr;
          wdata_d         = 16'h0;
          err_d           = bus.mem_err;
          starve_cnt_d    = 4'd0;
          state_d         = BUSY_I;
        end
      end
      BUSY_I: begin
        bus.mem_addr    = addr_q;
        bus.mem_data_in = wdata_q;
        if (bus.mem_done) begin
          bus.i_done     = 1'b1;
          bus.i_data_out = bus.mem_data_out;
          bus.i_err      = err_q | bus.mem_err;
          state_d        = IDLE;
        end
      end
      BUSY_D: begin
        bus.mem_addr    = addr_q;
        bus.mem_data_in = wdata_q;
        if (bus.mem_done) begin
          bus.d_done     = 1'b1;
          bus.d_data_out = bus.mem_data_out;
          bus.d_err      = err_q | bus.mem_err;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is asserted every output reads as idle, whatever the old state was
    if (rst) begin
      bus.mem_rd      = 1'b0;
      bus.mem_wr      = 1'b0;
      bus.mem_addr    = 16'h0;
      bus.mem_data_in = 16'h0;
      bus.i_done      = 1'b0;
      bus.i_err       = 1'b0;
      bus.i_data_out  = 16'h0;
      bus.d_done      = 1'b0;
      bus.d_err       = 1'b0;
      bus.d_data_out  = 16'h0;
    end
  end

  // Stall covers the wait for arbitration as well as the memory latency
  always_comb begin
    bus.i_stall = 1'b0;
    bus.d_stall = 1'b0;
    if (!rst) begin
      bus.i_stall = bus.i_rd & ~bus.i_done;
      bus.d_stall = d_req & ~bus.d_done;
    end
  end

  // State and latched-issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      err_q        <= 1'b0;
      addr_q       <= 16'h0;
      wdata_q      <= 16'h0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one multi-cycle memory (Rd/Wr strobe, Stall/Done/DataOut/err response) between the fetch stage (port I, read-only) and the memory stage (port D, read/write). Sits between the pipeline stages and the unified memory. Each port sees a stall-style handshake. Data port has priority, with a starvation guard for fetch.

## Interface

- STARVE_LIMIT, default 4: consecutive D grants while I is waiting before I is forced through once (range 1..15).

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_rd  in  1  fetch read request; held until i_done
- i_addr  in  16  fetch address
- i_data_out  out  16  read data; valid only while i_done=1
- i_done  out  1  one-cycle completion pulse
- i_stall  out  1  request pending, not complete
- i_err  out  1  error pulse, coincident with i_done
- d_rd  in  1  data read request; held until d_done
- d_wr  in  1  data write request; held until d_done
- d_addr  in  16  data address
- d_wr_data  in  16  write data
- d_data_out  out  16  read data; valid only while d_done=1
- d_done, d_stall, d_err  out  1 each  same meaning as the I port
- mem_rd, mem_wr  out  1 each  one-cycle issue strobes to memory
- mem_addr, mem_data_in  out  16 each  memory address and write data
- mem_done  in  1  memory completion pulse; mem_data_out valid with it
- mem_stall  in  1  memory busy (informational; not required for sequencing)
- mem_data_out  in  16  memory read data
- mem_err  in  1  memory error, sampled in the issue cycle

## Operation

- States: IDLE, BUSY_I, BUSY_D.
- IDLE, no request: all strobes 0, and mem_addr and mem_data_in are 0.
- IDLE, request present: select a port.
  - D is selected if d_rd|d_wr, unless starve_cnt==STARVE_LIMIT and i_rd, in which case I is selected.
  - Issue in the same cycle: mem_rd/mem_wr = the selected port's rd/wr, mem_addr and mem_data_in from that port.
  - Next state is BUSY_I or BUSY_D.
- Latching at issue: latch the grant, the address, the write data and mem_err (err_q).
- BUSY_x: hold mem_addr/mem_data_in at the latched values with strobes 0, and wait for mem_done.
- On mem_done in BUSY_x:
  - x_done=1 and x_data_out=mem_data_out (combinational pass-through).
  - x_err = err_q | mem_err.
  - Next state is IDLE.
- starve_cnt (4 bits):
  - Increments on each D issue while i_rd=1, saturating at STARVE_LIMIT.
  - Clears to 0 on any I issue.
  - Clears to 0 on any D issue while i_rd=0.
- Illegal request, d_rd & d_wr both 1 in IDLE:
  - No memory issue.
  - d_done=1 and d_err=1 for that cycle; stay in IDLE.
  - I may not issue in that cycle.
- x_stall = x request asserted & ~x_done. It includes the cycle the request waits for arbitration.
- A requester that drops its request before done is a protocol violation. The arbiter still completes the access and discards the result silently (done is still pulsed).

## Timing

- Reset values:
  - state=IDLE, starve_cnt=0, err_q=0.
  - All strobes, done, err and stall outputs are 0.
  - All data outputs and mem_addr/mem_data_in are 0.
- Latency: a request seen in IDLE at cycle N issues in cycle N. Done comes in the cycle mem_done arrives (N+k, k≥1).
- Next issue is at the earliest N+k+1; there is no back-to-back issue in the done cycle.
- mem_done while IDLE is ignored, and no done is generated.
- Simultaneous i_rd and d_rd/d_wr in IDLE: D wins unless starve_cnt==STARVE_LIMIT.
- Reset mid-access: the next state is IDLE and the access is abandoned, with no done. Memory is reset on the same rst.

## Test plan

- Single I read, memory latency 3: i_rd with i_addr=0x0010 at cycle 0 -> mem_rd=1 and mem_addr=0x0010 at cycle 0; i_stall=1 for cycles 0-2; i_done=1 with i_data_out=mem data at cycle 3; mem_rd=0 in cycles 1-3.
- D write, then I read requested at the same time: d_wr with addr 0x0020 and data 0xBEEF, plus i_rd -> D issues first (mem_wr=1, mem_data_in=0xBEEF); after d_done, I issues exactly 1 cycle later.
- Starvation, STARVE_LIMIT=4: d_rd and i_rd held continuously -> issue order D,D,D,D,I,D,… with starve_cnt reset after I.
- Illegal d_rd=d_wr=1 -> same-cycle d_done=1 and d_err=1, no mem strobe, state stays IDLE.
- mem_err=1 in the issue cycle of an I read -> i_err=1 coincident with i_done; D port unaffected.
- rst asserted in BUSY_D at cycle 2 of 4 -> cycle 3 shows all outputs 0 and state IDLE; a late mem_done produces no d_done; a new i_rd then issues normally.
